conv1d_pe: RTL

//  Parametrised 1-D convolution processing element. Successor to the single-channel PE.

---
 rtl/pe_pkg.sv | 44 ++++
 rtl/sat_mac.sv | 57 +++++
 rtl/conv1d_pe.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and saturating arithmetic helpers for the conv1d
// processing element.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    FINISH
  } pe_state_t;

  localparam logic LOAD_SEL_WEIGHT = 1'b0;
  localparam logic LOAD_SEL_ACT    = 1'b1;

  function automatic int out_size(
    input int act,
    input int k,
    input int stride
  );
    return (act - k) / stride + 1;
  endfunction

  function automatic logic signed [63:0] sat_narrow(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    return sat_narrow(a + b, w);
  endfunction

endpackage

// File: rtl/sat_mac.sv
// Two-stage multiply / saturating accumulate: the rescaled product is
// registered first, then folded into the accumulator one edge later.
import pe_pkg::*;

module sat_mac #(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int AW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr_first,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] a,
  output logic signed [AW-1:0] acc,
  output logic                 sat
);

  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] term_q;
  logic                   en_q;
  logic                   clr_q;
  logic signed [63:0]     base;
  logic signed [63:0]     raw;
  logic signed [63:0]     clamped;

  always_comb begin
    prod = (w * a) >>> FRAC;
  end

  always_comb begin
    base    = clr_q ? '0 : 64'(acc);
    raw     = base + 64'(term_q);
    clamped = sat_add(base, 64'(term_q), AW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      term_q <= '0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      acc    <= '0;
      sat    <= 1'b0;
    end else begin
      term_q <= prod;
      en_q   <= en;
      clr_q  <= clr_first;
      sat    <= 1'b0;
      if (en_q) begin
        acc <= clamped[AW-1:0];
        sat <= clamped != raw;
      end
    end
  end

endmodule

// File: rtl/conv1d_pe.sv
// Multi-channel strided 1-D convolution PE: local weight/activation
// register files, one saturating MAC per cycle, valid/ready result port.
import pe_pkg::*;

module conv1d_pe #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int KERNEL_SIZE  = 3,
  parameter int ACT_SIZE     = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int STRIDE       = 1,
  localparam int OUT_SIZE =
    out_size(ACT_SIZE, KERNEL_SIZE, STRIDE),
  localparam int IW = $clog2(OUT_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_sel,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]         out_index,
  output logic                  sat_flag
);

  localparam int KN  = KERNEL_SIZE * NUM_CHANNELS;
  localparam int AN  = ACT_SIZE * NUM_CHANNELS;
  localparam int WIW = $clog2(KN);
  localparam int AIW = $clog2(AN);
  localparam int TW  = $clog2(KN + 1);

  localparam logic [WIW-1:0] W_LAST = WIW'(KN - 1);
  localparam logic [AIW-1:0] A_LAST = AIW'(AN - 1);
  localparam logic [WIW-1:0] K_LAST = WIW'(KERNEL_SIZE - 1);
  localparam logic [TW-1:0]  T_END  = TW'(KN);
  localparam logic [IW-1:0]  P_LAST = IW'(OUT_SIZE - 1);
  localparam logic [AIW-1:0] A_STEP = AIW'(ACT_SIZE);
  localparam logic [AIW-1:0] P_STEP = AIW'(STRIDE);

  pe_state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] wrf [KN];
  logic signed [DATA_WIDTH-1:0] arf [AN];

  logic [WIW-1:0] wptr;
  logic [AIW-1:0] aptr;
  logic           w_ok;
  logic           a_ok;
  logic           alive;
  logic           idle_rdy;
  logic           start_ok;
  logic           beat;

  logic [TW-1:0]  t;
  logic [WIW-1:0] k;
  logic [AIW-1:0] c_off;
  logic [AIW-1:0] pbase;
  logic [AIW-1:0] pb;
  logic [IW-1:0]  p;
  logic           relu_l;
  logic           issue;
  logic           clr_first;
  logic [WIW-1:0] widx;
  logic [AIW-1:0] aidx;

  logic signed [DATA_WIDTH-1:0] mac_w;
  logic signed [DATA_WIDTH-1:0] mac_a;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         mac_sat;
  logic signed [63:0]           res;
  logic signed [63:0]           res_sat;
  logic                         out_clamp;

  assign idle_rdy = (state == IDLE) && alive;
  assign start_ok = start && idle_rdy && w_ok && a_ok;
  assign beat     = load_valid && idle_rdy && !start_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // The handshake edge issues the first term of the next position,
  // overlapping the output slot with the MAC pipeline fill.
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    clr_first  = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = alive;
        if (start_ok) state_nx = MAC;
      end
      MAC: begin
        busy      = 1'b1;
        issue     = t != T_END;
        clr_first = t == '0;
        if (t == T_END) state_nx = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (p == P_LAST) begin
            state_nx = FINISH;
          end else begin
            state_nx  = MAC;
            issue     = 1'b1;
            clr_first = 1'b1;
          end
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pb    = (state == OUT) ? pbase + P_STEP : pbase;
    aidx  = c_off + pb + AIW'(k);
    widx  = t[WIW-1:0];
    mac_w = wrf[widx];
    mac_a = arf[aidx];
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      if (load_sel == LOAD_SEL_WEIGHT) wrf[wptr] <= load_data;
      else                             arf[aptr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive     <= 1'b0;
      start_err <= 1'b0;
      wptr      <= '0;
      aptr      <= '0;
      w_ok      <= 1'b0;
      a_ok      <= 1'b0;
      t         <= '0;
      k         <= '0;
      c_off     <= '0;
      pbase     <= '0;
      p         <= '0;
      relu_l    <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      alive     <= 1'b1;
      start_err <= start && idle_rdy && !(w_ok && a_ok);
      if (beat && load_sel == LOAD_SEL_WEIGHT) begin
        wptr <= (wptr == W_LAST) ? '0 : wptr + 1'b1;
        w_ok <= wptr == W_LAST;
      end
      if (beat && load_sel == LOAD_SEL_ACT) begin
        aptr <= (aptr == A_LAST) ? '0 : aptr + 1'b1;
        a_ok <= aptr == A_LAST;
      end
      if (start_ok) begin
        relu_l <= relu_en;
        p      <= '0;
        pbase  <= '0;
      end
      if (issue) begin
        t <= t + 1'b1;
        if (k == K_LAST) begin
          k     <= '0;
          c_off <= c_off + A_STEP;
        end else begin
          k <= k + 1'b1;
        end
      end else if (state == MAC && t == T_END) begin
        t     <= '0;
        k     <= '0;
        c_off <= '0;
      end
      if (state == OUT && out_ready && p != P_LAST) begin
        p     <= p + 1'b1;
        pbase <= pbase + P_STEP;
      end
      if (start_ok)
        sat_flag <= 1'b0;
      else if (mac_sat || (out_valid && out_clamp))
        sat_flag <= 1'b1;
    end
  end

  sat_mac #(
    .DW   (DATA_WIDTH),
    .FRAC (FRAC_BITS),
    .AW   (ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .en        (issue),
    .clr_first (clr_first),
    .w         (mac_w),
    .a         (mac_a),
    .acc       (acc),
    .sat       (mac_sat)
  );

  always_comb begin
    res       = (relu_l && acc[ACC_WIDTH-1]) ? '0 : 64'(acc);
    res_sat   = sat_narrow(res, DATA_WIDTH);
    out_clamp = res_sat != res;
    out_data  = out_valid ? res_sat[DATA_WIDTH-1:0] : '0;
    out_index = out_valid ? p : '0;
  end

endmodule
